// File: rtl/unified_memory_arbiter_pkg.sv
// Shared types for the rv32i memory path: access sizes, arbiter response
// selector and the alignment helper used by the arbiter.
package unified_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2
    } mem_access_t;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_I    = 2'd1,
        RSP_D    = 2'd2
    } rsp_sel_t;

    localparam int WAIT_CNT_W = 4;

    // Unknown access encodings are treated as byte-sized (never misaligned).
    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input mem_access_t access);
        case (access)
            MEM_ACCESS_HALF: return addr_lo[0];
            MEM_ACCESS_WORD: return |addr_lo;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/unified_memory_arbiter_wait_counter.sv
// Starvation counter for the instruction port: counts consecutive cycles the
// fetch request is denied and raises o_force once the limit is reached.
module arbiter_wait_counter
    import unified_memory_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_ifetch_valid,
    input  logic                  i_grant_i,
    input  logic                  i_grant_d,
    output logic                  o_force,
    output logic [WAIT_CNT_W-1:0] o_wait_cnt
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (!i_ifetch_valid || i_grant_i) begin
            r_wait_cnt <= '0;
        end else if (i_grant_d && (r_wait_cnt < LIMIT)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign o_force    = i_ifetch_valid & (r_wait_cnt >= LIMIT);
    assign o_wait_cnt = r_wait_cnt;

endmodule

// File: rtl/unified_memory_arbiter.sv
// Arbitrates one single-port RAM between instruction fetch and load/store.
// Data port wins by default; a starved fetch is forced through after MAX_WAIT.
module unified_memory_arbiter
    import unified_memory_arbiter_pkg::*;
#(
    parameter int W        = 32,
    parameter int MAX_WAIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction fetch port
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [31:0]           i_addr,
    output logic                  i_rsp_valid,
    output logic [W-1:0]          i_rsp_data,
    output logic                  i_rsp_fault,
    // load/store port
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic                  d_wr_ena,
    input  mem_access_t           d_access,
    input  logic [31:0]           d_addr,
    input  logic [W-1:0]          d_wr_data,
    output logic                  d_rsp_valid,
    output logic [W-1:0]          d_rsp_data,
    output logic                  d_rsp_fault,
    // RAM side
    output logic                  mem_wr_ena,
    output mem_access_t           mem_access,
    output logic [31:0]           mem_addr,
    output logic [W-1:0]          mem_wr_data,
    input  logic [W-1:0]          mem_rd_data,
    input  logic                  mem_active,
    // debug visibility
    output rsp_sel_t              o_dbg_rsp_sel,
    output logic [WAIT_CNT_W-1:0] o_dbg_wait_cnt
);

    // Valid/ready: a request transfers in the cycle where valid & ready are
    // both high; ready is combinational and at most one port is granted per
    // cycle. Responses follow one cycle later and cannot be back-pressured.

    logic     w_force_i;
    logic     w_grant_i;
    logic     w_grant_d;
    logic     w_fault;
    logic     w_store;
    logic [W-1:0] w_rsp_data;
    rsp_sel_t r_rsp_sel;
    rsp_sel_t w_rsp_sel_next;

    logic [W-1:0] r_i_rsp_data;
    logic         r_i_rsp_fault;
    logic [W-1:0] r_d_rsp_data;
    logic         r_d_rsp_fault;

    arbiter_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk            (clk),
        .rst            (rst),
        .i_ifetch_valid (i_req_valid),
        .i_grant_i      (w_grant_i),
        .i_grant_d      (w_grant_d),
        .o_force        (w_force_i),
        .o_wait_cnt     (o_dbg_wait_cnt)
    );

    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (!rst) begin
            if (w_force_i) begin
                w_grant_i = 1'b1;
            end else if (d_req_valid) begin
                w_grant_d = 1'b1;
            end else if (i_req_valid) begin
                w_grant_i = 1'b1;
            end
        end
    end

    assign i_req_ready = w_grant_i;
    assign d_req_ready = w_grant_d;

    // With no grant the RAM still sees the D-port address; only wr_ena is idle.
    always_comb begin
        mem_addr    = d_addr;
        mem_access  = d_access;
        mem_wr_data = d_wr_data;
        if (w_grant_i) begin
            mem_addr   = i_addr;
            mem_access = MEM_ACCESS_WORD;
        end
    end

    assign w_fault    = is_misaligned(mem_addr[1:0], mem_access) | ~mem_active;
    assign w_store    = w_grant_d & d_wr_ena;
    assign mem_wr_ena = w_store & ~w_fault;
    assign w_rsp_data = (w_fault || w_store) ? '0 : mem_rd_data;

    always_comb begin
        w_rsp_sel_next = RSP_NONE;
        if (w_grant_i) begin
            w_rsp_sel_next = RSP_I;
        end else if (w_grant_d) begin
            w_rsp_sel_next = RSP_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_sel <= RSP_NONE;
        end else begin
            r_rsp_sel <= w_rsp_sel_next;
        end
    end

    // Only the granted port's payload registers update; the other holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_rsp_data  <= '0;
            r_i_rsp_fault <= 1'b0;
            r_d_rsp_data  <= '0;
            r_d_rsp_fault <= 1'b0;
        end else begin
            if (w_grant_i) begin
                r_i_rsp_data  <= w_rsp_data;
                r_i_rsp_fault <= w_fault;
            end
            if (w_grant_d) begin
                r_d_rsp_data  <= w_rsp_data;
                r_d_rsp_fault <= w_fault;
            end
        end
    end

    assign i_rsp_valid   = (r_rsp_sel == RSP_I);
    assign d_rsp_valid   = (r_rsp_sel == RSP_D);
    assign i_rsp_data    = r_i_rsp_data;
    assign i_rsp_fault   = r_i_rsp_fault;
    assign d_rsp_data    = r_d_rsp_data;
    assign d_rsp_fault   = r_d_rsp_fault;
    assign o_dbg_rsp_sel = r_rsp_sel;

endmodule
